// File: rtl/as_wb_intercon_if.sv
// Wishbone interconnect bundle: NM master ports and NS slave ports, plus grant
// and error reporting.
//   m_*_i / m_*_o : per-master request in, response out (master k in slice k)
//   s_*_o / s_*_i : per-slave cyc/stb, shared we/adr/dat/sel, per-slave dat/ack
//   gnt_o, bus_err_o, err_adr_o, err_to_o : arbitration and error status
// Modport slave is the fabric's view (it serves the masters). Modport master
// is the view of whatever drives the masters' requests and the slaves'
// responses.
interface as_wb_intercon_if #(
  parameter int unsigned NM = 2,
  parameter int unsigned NS = 4,
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64,
  parameter int unsigned SW = 8
);
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM*DW-1:0] m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NS-1:0]    s_cyc_o;
  logic [NS-1:0]    s_stb_o;
  logic             s_we_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [SW-1:0]    s_sel_o;
  logic [NS*DW-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i;
  logic [NM-1:0]    gnt_o;
  logic             bus_err_o;
  logic [AW-1:0]    err_adr_o;
  logic             err_to_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
           s_sel_o, gnt_o, bus_err_o, err_adr_o, err_to_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
           s_sel_o, gnt_o, bus_err_o, err_adr_o, err_to_o
  );
endinterface

// File: rtl/as_wb_intercon.sv
// Parametrised Wishbone interconnect: round-robin arbitration over NM masters,
// base/mask address decode over NS slaves, combinational request/response
// routing, a one-cycle bus error for unmapped addresses and a watchdog error
// for slaves that never acknowledge.
//   clk_i : rising-edge clock
//   rst_i : synchronous active-high reset
//   bus   : as_wb_intercon_if.slave (all master, slave and status signals)
module as_wb_intercon #(
  parameter int unsigned      NM       = 2,
  parameter int unsigned      NS       = 4,
  parameter int unsigned      AW       = 64,
  parameter int unsigned      DW       = 64,
  parameter int unsigned      SW       = 8,
  parameter logic [NS*AW-1:0] SLV_BASE = '0,
  parameter logic [NS*AW-1:0] SLV_MASK = '0,
  parameter int unsigned      TIMEOUT  = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  as_wb_intercon_if.slave bus
);

  localparam int unsigned     MIW      = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned     SIW      = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned     WDW      = 16;
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [MIW-1:0]  LAST_RST = MIW'(NM - 1);

  typedef enum logic {S_IDLE, S_OWN} state_e;

  state_e         state_q, state_d;
  logic [NM-1:0]  gnt_q, gnt_d;
  logic [MIW-1:0] own_q, own_d;
  logic [MIW-1:0] last_q, last_d;
  logic           req_found;
  logic [MIW-1:0] req_idx;
  logic [MIW-1:0] cand;

  logic           own_v, o_cyc, o_stb, o_we;
  logic [AW-1:0]  o_adr;
  logic [DW-1:0]  o_dat;
  logic [SW-1:0]  o_sel;

  logic           hit;
  logic [SIW-1:0] sel;
  logic           s_ack_sel;
  logic [DW-1:0]  s_dat_sel;

  logic           err_q, err_d;
  logic           err_to_q, err_to_d;
  logic [AW-1:0]  err_adr_q, err_adr_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           wd_run, unm_fire, to_fire;

  // Round-robin search: first requester starting after the previous owner
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NM; i++) begin
      cand = MIW'((32'(last_q) + i) % NM);
      if (!req_found && bus.m_cyc_i[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
    end
  end

  // Arbiter next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_found) state_d = S_OWN;
      S_OWN:   if (!bus.m_cyc_i[own_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Arbiter outputs: grant vector, owner index and round-robin pointer
  always_comb begin
    gnt_d  = gnt_q;
    own_d  = own_q;
    last_d = last_q;
    case (state_q)
      S_IDLE: begin
        if (req_found) begin
          gnt_d          = '0;
          gnt_d[req_idx] = 1'b1;
          own_d          = req_idx;
        end
      end
      S_OWN: begin
        if (!bus.m_cyc_i[own_q]) begin
          gnt_d  = '0;
          last_d = own_q;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  // Owner's request, forced to zero while nobody holds the bus
  assign own_v = (state_q == S_OWN);

  always_comb begin
    o_cyc = 1'b0;
    o_stb = 1'b0;
    o_we  = 1'b0;
    o_adr = '0;
    o_dat = '0;
    o_sel = '0;
    if (own_v) begin
      o_cyc = bus.m_cyc_i[own_q];
      o_stb = bus.m_stb_i[own_q];
      o_we  = bus.m_we_i[own_q];
      o_adr = bus.m_adr_i[own_q*AW +: AW];
      o_dat = bus.m_dat_i[own_q*DW +: DW];
      o_sel = bus.m_sel_i[own_q*SW +: SW];
    end
  end

  // Address decode; the lowest matching slave index wins
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (!hit && ((o_adr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
        hit = 1'b1;
        sel = SIW'(i);
      end
    end
  end

  // Request path to the selected slave
  always_comb begin
    bus.s_cyc_o = '0;
    bus.s_stb_o = '0;
    if (hit) begin
      bus.s_cyc_o[sel] = o_cyc;
      bus.s_stb_o[sel] = o_stb;
    end
  end

  assign bus.s_we_o  = o_we;
  assign bus.s_adr_o = o_adr;
  assign bus.s_dat_o = o_dat;
  assign bus.s_sel_o = o_sel;

  // Response path back to the owner only
  assign s_ack_sel = hit & bus.s_ack_i[sel];
  assign s_dat_sel = hit ? bus.s_dat_i[sel*DW +: DW] : '0;

  always_comb begin
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_dat_o = '0;
    if (own_v) begin
      bus.m_ack_o[own_q]           = s_ack_sel;
      bus.m_err_o[own_q]           = err_q;
      bus.m_dat_o[own_q*DW +: DW]  = s_dat_sel;
    end
  end

  // Error sources: unmapped strobe (never on back-to-back cycles) and watchdog.
  // An ack in the watchdog's last cycle keeps wd_run low, so the ack wins.
  assign wd_run   = o_cyc & o_stb & hit & ~s_ack_sel;
  assign unm_fire = o_cyc & o_stb & ~hit & ~err_q;
  assign to_fire  = wd_run & (wd_q == WD_LAST);

  always_comb begin
    err_d     = unm_fire | to_fire;
    err_to_d  = err_to_q;
    err_adr_d = err_adr_q;
    wd_d      = '0;
    if (wd_run && !to_fire) wd_d = wd_q + WDW'(1);
    if (unm_fire || to_fire) begin
      err_to_d  = to_fire;
      err_adr_d = o_adr;
    end
  end

  // Error and watchdog registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      err_to_q  <= 1'b0;
      err_adr_q <= '0;
      wd_q      <= '0;
    end else begin
      err_q     <= err_d;
      err_to_q  <= err_to_d;
      err_adr_q <= err_adr_d;
      wd_q      <= wd_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.bus_err_o = err_q;
  assign bus.err_adr_o = err_adr_q;
  assign bus.err_to_o  = err_to_q;

endmodule

// File: tb/tb_as_wb_intercon.sv
// Self-checking bench for as_wb_intercon: directed cycle-accurate checks plus
// a response scoreboard (expected ack/error pushed when stimulus is applied,
// popped whenever a master sees ack or err).
module tb_as_wb_intercon;

  localparam int unsigned NM = 2;
  localparam int unsigned NS = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 8;
  localparam int unsigned TO = 8;

  localparam logic [AW-1:0]    MSK   = 64'hFFFF_FFFF_FFFF_0000;
  localparam logic [NS*AW-1:0] BASES = {64'h4_0000, 64'h3_0000, 64'h1_0000, 64'h0};
  localparam logic [NS*AW-1:0] MASKS = {MSK, MSK, MSK, MSK};

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  as_wb_intercon_if #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SW(SW)) bus ();

  as_wb_intercon #(
    .NM(NM), .NS(NS), .AW(AW), .DW(DW), .SW(SW),
    .SLV_BASE(BASES), .SLV_MASK(MASKS), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    int          m;
    bit          is_err;
    bit          to;
    logic [63:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int m, input bit is_err, input bit to, input logic [63:0] val);
    exp_t e;
    e.m = m; e.is_err = is_err; e.to = to; e.val = val;
    sbq.push_back(e);
  endtask

  task automatic drv(input int m, input logic cyc, input logic stb, input logic we,
                     input logic [AW-1:0] adr);
    bus.m_cyc_i[m]            = cyc;
    bus.m_stb_i[m]            = stb;
    bus.m_we_i[m]             = we;
    bus.m_adr_i[m*AW +: AW]   = adr;
    bus.m_dat_i[m*DW +: DW]   = {32'hA5A5_0000, 32'(m)};
    bus.m_sel_i[m*SW +: SW]   = '1;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    for (int m = 0; m < NM; m++) begin
      if (bus.m_ack_o[m] || bus.m_err_o[m]) begin
        exp_t e;
        if (sbq.size() == 0) begin
          chk("sb_unexpected_resp", 64'(m) + 64'h100, 64'h0);
        end else begin
          e = sbq.pop_front();
          chk("sb_master", 64'(m), 64'(e.m));
          chk("sb_kind_err", 64'(bus.m_err_o[m]), 64'(e.is_err));
          chk("sb_kind_ack", 64'(bus.m_ack_o[m]), 64'(!e.is_err));
          if (e.is_err) begin
            chk("sb_bus_err", 64'(bus.bus_err_o), 64'h1);
            chk("sb_err_adr", bus.err_adr_o, e.val);
            chk("sb_err_to", 64'(bus.err_to_o), 64'(e.to));
          end else begin
            chk("sb_rdata", bus.m_dat_o[m*DW +: DW], e.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL tb_time_limit: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = '0;
    for (int i = 0; i < NS; i++) bus.s_dat_i[i*DW +: DW] = 64'hD00D_0000 + 64'(i);

    // Reset state
    nxt(); nxt();
    smp();
    chk("rst_gnt", 64'(bus.gnt_o), 64'h0);
    chk("rst_stb", 64'(bus.s_stb_o), 64'h0);
    chk("rst_bus_err", 64'(bus.bus_err_o), 64'h0);
    chk("rst_err_adr", bus.err_adr_o, 64'h0);
    chk("rst_err_to", 64'(bus.err_to_o), 64'h0);
    chk("rst_resp", 64'({bus.m_ack_o, bus.m_err_o}), 64'h0);

    // Simple read from slave 0, combinational ack
    nxt(); rst = 1'b0; drv(0, 1, 1, 0, 64'h0);
    smp(); chk("t1_gnt_t0", 64'(bus.gnt_o), 64'h0);
    nxt(); bus.s_dat_i[0 +: DW] = 64'h1234; bus.s_ack_i = 4'b0001; push(0, 0, 0, 64'h1234);
    smp();
    chk("t1_gnt_t1", 64'(bus.gnt_o), 64'h1);
    chk("t1_s_stb", 64'(bus.s_stb_o), 64'h1);
    chk("t1_ack", 64'(bus.m_ack_o), 64'h1);
    chk("t1_m1_dat_zero", bus.m_dat_o[DW +: DW], 64'h0);
    nxt(); bus.s_ack_i = '0; drv(0, 0, 0, 0, 64'h0);
    smp(); chk("t1_gnt_hold", 64'(bus.gnt_o), 64'h1);
    nxt();
    smp(); chk("t1_gnt_released", 64'(bus.gnt_o), 64'h0);

    // Round robin 0 -> 1 -> 0 with an idle cycle at every handover
    nxt(); rst = 1'b1; drv(0, 1, 0, 0, 64'h0); drv(1, 1, 1, 0, 64'h1_0000);
    nxt(); rst = 1'b0;
    smp(); chk("t2_after_rst", 64'(bus.gnt_o), 64'h0);
    nxt(); drv(0, 0, 0, 0, 64'h0); bus.s_ack_i = 4'b0010;
    smp();
    chk("t2_gnt_m0", 64'(bus.gnt_o), 64'h1);
    chk("t2_no_ack_leak", 64'(bus.m_ack_o), 64'h0);
    chk("t2_no_stb_leak", 64'(bus.s_stb_o), 64'h0);
    nxt(); drv(0, 1, 0, 0, 64'h0); bus.s_ack_i = '0;
    smp(); chk("t2_idle_1", 64'(bus.gnt_o), 64'h0);
    nxt(); drv(1, 0, 0, 0, 64'h1_0000);
    smp(); chk("t2_gnt_m1", 64'(bus.gnt_o), 64'h2);
    nxt();
    smp(); chk("t2_idle_2", 64'(bus.gnt_o), 64'h0);
    nxt(); drv(0, 0, 0, 0, 64'h0);
    smp(); chk("t2_gnt_m0_again", 64'(bus.gnt_o), 64'h1);
    nxt();
    smp(); chk("t2_end_idle", 64'(bus.gnt_o), 64'h0);

    // Unmapped write: error one cycle after the strobe
    nxt(); drv(0, 1, 0, 1, 64'h2_0000);
    nxt(); drv(0, 1, 1, 1, 64'h2_0000); push(0, 1, 0, 64'h2_0000);
    smp();
    chk("t3_gnt", 64'(bus.gnt_o), 64'h1);
    chk("t3_no_s_stb", 64'(bus.s_stb_o), 64'h0);
    chk("t3_no_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    chk("t3_s_adr", bus.s_adr_o, 64'h2_0000);
    chk("t3_s_we", 64'(bus.s_we_o), 64'h1);
    chk("t3_m0_dat_zero", bus.m_dat_o[0 +: DW], 64'h0);
    chk("t3_no_err_yet", 64'(bus.bus_err_o), 64'h0);
    nxt(); drv(0, 1, 0, 1, 64'h2_0000);
    smp(); chk("t3_m_err", 64'(bus.m_err_o), 64'h1);
    nxt(); drv(0, 0, 0, 0, 64'h0);
    smp();
    chk("t3_single_pulse", 64'(bus.bus_err_o), 64'h0);
    chk("t3_err_adr_held", bus.err_adr_o, 64'h2_0000);
    chk("t3_err_to", 64'(bus.err_to_o), 64'h0);

    // Watchdog: slave 1 never acks, error exactly TO cycles after the first strobe
    nxt(); drv(0, 1, 0, 0, 64'h1_0000);
    nxt(); drv(0, 1, 1, 0, 64'h1_0000); push(0, 1, 1, 64'h1_0000);
    for (int i = 0; i < int'(TO); i++) begin
      smp(); chk("t4_quiet", 64'(bus.bus_err_o), 64'h0);
      nxt();
    end
    smp();
    chk("t4_m_err", 64'(bus.m_err_o), 64'h1);
    chk("t4_wd_cleared", 64'(dut.wd_q), 64'h0);
    nxt(); drv(0, 0, 0, 0, 64'h0);
    smp(); chk("t4_after", 64'(bus.bus_err_o), 64'h0);

    // Watchdog boundary: ack in the last counting cycle wins over the error
    nxt(); drv(0, 1, 0, 0, 64'h1_0000);
    nxt(); drv(0, 1, 1, 0, 64'h1_0000);
    for (int i = 0; i < int'(TO) - 1; i++) begin
      smp(); chk("t5_quiet", 64'(bus.bus_err_o), 64'h0);
      nxt();
    end
    bus.s_ack_i = 4'b0010; bus.s_dat_i[DW +: DW] = 64'hCAFE; push(0, 0, 0, 64'hCAFE);
    smp();
    chk("t5_ack", 64'(bus.m_ack_o), 64'h1);
    chk("t5_no_err_ack_cycle", 64'(bus.bus_err_o), 64'h0);
    nxt(); bus.s_ack_i = '0; drv(0, 1, 0, 0, 64'h1_0000);
    smp();
    chk("t5_no_err_next", 64'(bus.bus_err_o), 64'h0);
    chk("t5_no_m_err", 64'(bus.m_err_o), 64'h0);
    nxt(); drv(0, 0, 0, 0, 64'h0);

    // Reset while master 1 owns the bus with a timeout about to fire
    nxt(); drv(1, 1, 0, 0, 64'h1_0000);
    nxt(); drv(1, 1, 1, 0, 64'h1_0000);
    for (int i = 0; i < int'(TO) - 1; i++) nxt();
    rst = 1'b1; drv(0, 1, 0, 0, 64'h0);
    smp(); chk("t6_gnt_m1", 64'(bus.gnt_o), 64'h2);
    nxt(); rst = 1'b0;
    smp();
    chk("t6_gnt_cleared", 64'(bus.gnt_o), 64'h0);
    chk("t6_no_err", 64'(bus.bus_err_o), 64'h0);
    chk("t6_no_m_err", 64'(bus.m_err_o), 64'h0);
    chk("t6_err_adr_cleared", bus.err_adr_o, 64'h0);
    chk("t6_err_to_cleared", 64'(bus.err_to_o), 64'h0);
    nxt();
    smp();
    chk("t6_m0_wins", 64'(bus.gnt_o), 64'h1);
    chk("t6_still_no_err", 64'(bus.bus_err_o), 64'h0);
    nxt(); drv(0, 0, 0, 0, 64'h0); drv(1, 0, 0, 0, 64'h0);
    nxt(); nxt();
    smp();
    chk("sb_drained", 64'(sbq.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/as_wb_intercon.md
# as_wb_intercon

Parametrised Wishbone data-bus interconnect that replaces the fixed single-master, four-slave decoder, read-data mux and pass-through arbiter in the SoC top level. It arbitrates `NM` masters with round-robin fairness and decodes `NS` slaves from base/mask parameters. It routes strobe, write data, read data and acknowledge between the granted master and the selected slave. It adds two features the fixed fabric lacks: a bus-error response for unmapped addresses and a watchdog timeout for slaves that never acknowledge.

## Interface
- `NM`, 2: number of masters (1..8)
- `NS`, 4: number of slaves (1..16)
- `AW`, 64: address width
- `DW`, 64: data width
- `SW`, 8: byte-select width (DW/8)
- `SLV_BASE`, {NS{AW'h0}}: packed array; slave i base address
- `SLV_MASK`, {NS{AW'h0}}: packed array; slave i decode mask
- `TIMEOUT`, 255: cycles of unacknowledged strobe before a forced error (2..65535)

Ports:
- `clk_i`  in  1  single clock; every flop is rising-edge
- `rst_i`  in  1  synchronous, active-high reset
- `m_cyc_i`, `m_stb_i`, `m_we_i`  in  NM each  per-master cycle, strobe and write-enable
- `m_adr_i`  in  NM*AW  per-master address (master k at [k*AW +: AW])
- `m_dat_i`  in  NM*DW  per-master write data
- `m_sel_i`  in  NM*SW  per-master byte select
- `m_dat_o`  out  NM*DW  per-master read data
- `m_ack_o`, `m_err_o`  out  NM each  per-master ack and error
- `s_cyc_o`, `s_stb_o`  out  NS each  per-slave cycle and strobe
- `s_we_o`, `s_adr_o`, `s_dat_o`, `s_sel_o`  out  1/AW/DW/SW  shared, driven from the granted master
- `s_dat_i`  in  NS*DW  per-slave read data
- `s_ack_i`  in  NS  per-slave ack
- `gnt_o`  out  NM  one-hot current grant
- `bus_err_o`  out  1  one-cycle pulse for every error, whether unmapped or timeout
- `err_adr_o`  out  AW  address of the most recent error
- `err_to_o`  out  1  1 if the most recent error was a timeout, 0 if unmapped

## Operation
- Arbiter FSM with two states: IDLE and OWN.
  - IDLE: if any `m_cyc_i` is set, register the grant and enter OWN. The search starts at index `last+1` modulo NM and takes the first requester found. `last` holds the index of the previous owner.
  - OWN: keep the grant while the owner's `m_cyc_i` is 1. When it drops, clear `gnt_o`, set `last` to the owner index, and return to IDLE.
- Decode is combinational on the granted master's address. Slave i matches when `(adr & SLV_MASK[i]) == SLV_BASE[i]`. If several slaves match, the lowest index wins. If none match, the access is unmapped.
- `s_cyc_o[i]` = owner cyc & match_i. `s_stb_o[i]` = owner stb & match_i. All other slaves see 0.
- The shared slave signals carry the owner's values. With no owner they are all zero.
- Return path: `m_dat_o`, `m_ack_o` and `m_err_o` are driven only to the owner; every non-owner sees zeros.
  - The owner's `m_dat_o` is the selected slave's `s_dat_i`, or 0 when the access is unmapped.
  - The owner's `m_ack_o` is the selected slave's `s_ack_i`. It is combinational, so a slave's ack reaches the master in the same cycle.
- Unmapped error: a registered pulse. `err_q` <= stb & cyc & unmapped & ~err_q, so `m_err_o` is high for exactly one cycle per strobe, one cycle after the strobe is seen.
- Watchdog: a 16-bit counter.
  - Increments every cycle the owner has stb=1 on a mapped slave and no ack.
  - Clears on ack, on stb=0, or on a grant change.
  - When the count reaches TIMEOUT-1, the next cycle drives `m_err_o`=1 for one cycle and the counter clears.
  - A slave ack arriving in that same cycle wins: ack is issued, error is suppressed.
- Every error pulses `bus_err_o` and loads `err_adr_o` and `err_to_o` in the same cycle as `m_err_o`.

## Timing
- During reset:
  - All outputs are 0, including `gnt_o`, `err_adr_o` and `err_to_o`.
  - FSM is in IDLE, watchdog counter is 0.
  - `last` = NM-1, so master 0 wins the first arbitration.
- Arbitration latency is one cycle: `m_cyc_i` rising in cycle t gives `gnt_o` in t+1 and a slave strobe in t+1.
- Handover costs one idle cycle: the owner dropping cyc in cycle t means no grant in t+1 and a new grant in t+2.
- A mapped access has zero added latency, because ack is combinational.
- Unmapped error arrives at t+1 relative to the strobe.
- Timeout error arrives exactly TIMEOUT cycles after the first unacknowledged strobe cycle.
- Reset asserted mid-cycle takes effect at the next edge:
  - grant and all strobes drop;
  - a pending error or timeout is discarded;
  - `err_adr_o` clears.
- A master that drops cyc while its error is pending loses that pulse; the error is not delivered.

## Test plan
- Reset, then master 0 reads 0x0 (slave 0 base 0x0, mask 0xFFFF_0000) while slave 0 acks with data 0x1234 -> `gnt_o`=01 at t+1; `m_dat_o[0]`=0x1234 and ack appear in the same cycle as the slave ack.
- Masters 0 and 1 both hold cyc from reset -> grant order is 0, then 1, then 0, with one idle cycle between owners; master 1 never sees an ack while master 0 owns the bus.
- Master 0 writes to address 0x2_0000, which no slave maps -> no `s_stb_o` bit set; `m_err_o[0]`, `bus_err_o`=1 for one cycle at t+1; `err_adr_o`=0x2_0000, `err_to_o`=0.
- TIMEOUT=8 and slave 1 never acks -> `m_err_o` pulses exactly 8 cycles after the strobe; `err_to_o`=1; counter is back at 0 afterwards.
- TIMEOUT=8 and slave 1 acks in cycle 8 -> ack is delivered and no error is issued.
- Reset asserted while master 1 owns the bus with a pending timeout -> next cycle `gnt_o`=0, no error, and master 0 wins the next arbitration.
